serdesphy_pma_seq: RTL and testbench



---
 rtl/serdesphy_pkg.sv | 86 ++++++++
 rtl/serdesphy_sync2.sv | 21 ++
 rtl/serdesphy_pma_seq.sv | 128 ++++++++++++
 tb/tb_serdesphy_pma_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// Shared definitions for the SerDes PHY PMA power-up sequencer:
// state codes, timing defaults and the per-state control decode.
package serdesphy_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_ISO_REL   = 3'd1,
    ST_ANA_RST   = 3'd2,
    ST_PLL_START = 3'd3,
    ST_PLL_LOCK  = 3'd4,
    ST_LANE_UP   = 3'd5,
    ST_ACTIVE    = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  localparam int ISO_CYC_DEF   = 24;
  localparam int RST_CYC_DEF   = 48;
  localparam int LOCK_FILT_DEF = 64;
  localparam int LOCK_TO_DEF   = 24000;

  localparam int TMR_W  = 15;
  localparam int FILT_W = 7;

  typedef struct packed {
    logic analog_iso_n;
    logic analog_reset_n;
    logic pll_iso_n;
    logic pll_enable;
    logic pll_reset_n;
    logic serializer_enable;
    logic serializer_reset_n;
    logic deserializer_enable;
    logic deserializer_reset_n;
    logic pll_lock;
    logic phy_ready;
    logic seq_fault;
  } ctl_t;

  // Control levels held while resident in a state; each step of the
  // bring-up keeps everything the previous step had released.
  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      ST_ISO_REL: begin
        c.analog_iso_n = 1'b1;
        c.pll_iso_n    = 1'b1;
      end
      ST_ANA_RST: begin
        c.analog_iso_n   = 1'b1;
        c.pll_iso_n      = 1'b1;
        c.analog_reset_n = 1'b1;
      end
      ST_PLL_START: begin
        c.analog_iso_n   = 1'b1;
        c.pll_iso_n      = 1'b1;
        c.analog_reset_n = 1'b1;
        c.pll_enable     = 1'b1;
      end
      ST_PLL_LOCK: begin
        c.analog_iso_n   = 1'b1;
        c.pll_iso_n      = 1'b1;
        c.analog_reset_n = 1'b1;
        c.pll_enable     = 1'b1;
        c.pll_reset_n    = 1'b1;
      end
      ST_LANE_UP, ST_ACTIVE: begin
        c.analog_iso_n         = 1'b1;
        c.pll_iso_n            = 1'b1;
        c.analog_reset_n       = 1'b1;
        c.pll_enable           = 1'b1;
        c.pll_reset_n          = 1'b1;
        c.serializer_enable    = 1'b1;
        c.serializer_reset_n   = 1'b1;
        c.deserializer_enable  = 1'b1;
        c.deserializer_reset_n = 1'b1;
        c.pll_lock             = 1'b1;
        c.phy_ready            = (s == ST_ACTIVE);
      end
      ST_FAULT: c.seq_fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serdesphy_sync2.sv
// Two-flop synchronizer for one asynchronous status bit, async reset to 0.
module serdesphy_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serdesphy_pma_seq.sv
// PMA power-up sequencer: isolation release, analog reset, PLL start and
// lock qualification, lane bring-up, with sticky fault on lock/lane timeout.
//
// state     | meaning
// OFF       | everything isolated and held in reset
// ISO_REL   | analog and PLL isolation released
// ANA_RST   | analog reset released
// PLL_START | PLL enabled, still held in reset
// PLL_LOCK  | PLL running, filtering lock/vco/cp status
// LANE_UP   | lanes enabled, waiting for both ready
// ACTIVE    | link up; loss of raw lock faults
// FAULT     | all controls off, seq_fault held until phy_en drops
module serdesphy_pma_seq
  import serdesphy_pkg::*;
#(
  parameter int ISO_CYC   = ISO_CYC_DEF,
  parameter int RST_CYC   = RST_CYC_DEF,
  parameter int LOCK_FILT = LOCK_FILT_DEF,
  parameter int LOCK_TO   = LOCK_TO_DEF
) (
  input  logic       clk_ref_24m,
  input  logic       rst_n,
  input  logic       phy_en,
  input  logic       pll_lock_raw,
  input  logic       pll_vco_ok,
  input  logic       pll_cp_ok,
  input  logic       serializer_ready,
  input  logic       deserializer_ready,
  output logic       analog_iso_n,
  output logic       analog_reset_n,
  output logic       pll_iso_n,
  output logic       pll_enable,
  output logic       pll_reset_n,
  output logic       serializer_enable,
  output logic       serializer_reset_n,
  output logic       deserializer_enable,
  output logic       deserializer_reset_n,
  output logic       pll_lock,
  output logic       phy_ready,
  output logic       seq_fault,
  output logic [2:0] seq_state
);

  localparam logic [TMR_W-1:0]  ISO_LAST  = TMR_W'(ISO_CYC - 1);
  localparam logic [TMR_W-1:0]  RST_LAST  = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(LOCK_TO - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);

  logic pll_lock_raw_s, pll_vco_ok_s, pll_cp_ok_s;
  logic serializer_ready_s, deserializer_ready_s;

  serdesphy_sync2 u_sync_lock (.clk(clk_ref_24m), .rst_n(rst_n), .d(pll_lock_raw),       .q(pll_lock_raw_s));
  serdesphy_sync2 u_sync_vco  (.clk(clk_ref_24m), .rst_n(rst_n), .d(pll_vco_ok),         .q(pll_vco_ok_s));
  serdesphy_sync2 u_sync_cp   (.clk(clk_ref_24m), .rst_n(rst_n), .d(pll_cp_ok),          .q(pll_cp_ok_s));
  serdesphy_sync2 u_sync_ser  (.clk(clk_ref_24m), .rst_n(rst_n), .d(serializer_ready),   .q(serializer_ready_s));
  serdesphy_sync2 u_sync_des  (.clk(clk_ref_24m), .rst_n(rst_n), .d(deserializer_ready), .q(deserializer_ready_s));

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [FILT_W-1:0]  filt, filt_nxt;
  ctl_t               ctl;
  logic               lock_qual;

  assign lock_qual = pll_lock_raw_s & pll_vco_ok_s & pll_cp_ok_s;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_OFF:       if (phy_en) state_nxt = ST_ISO_REL;
      ST_ISO_REL:   if (timer == ISO_LAST) state_nxt = ST_ANA_RST;
      ST_ANA_RST:   if (timer == RST_LAST) state_nxt = ST_PLL_START;
      ST_PLL_START: if (timer == RST_LAST) state_nxt = ST_PLL_LOCK;
      ST_PLL_LOCK: begin
        if (lock_qual && filt == FILT_LAST) state_nxt = ST_LANE_UP;
        else if (timer == TO_LAST)          state_nxt = ST_FAULT;
      end
      ST_LANE_UP: begin
        if (serializer_ready_s && deserializer_ready_s) state_nxt = ST_ACTIVE;
        else if (timer == TO_LAST)                      state_nxt = ST_FAULT;
      end
      ST_ACTIVE:    if (!pll_lock_raw_s) state_nxt = ST_FAULT;
      ST_FAULT:     state_nxt = ST_FAULT;
    endcase
    // Dropping the enable wins over any timeout or lock event this cycle.
    if (!phy_en && state != ST_OFF) state_nxt = ST_OFF;
  end

  always_comb begin
    timer_nxt = '0;
    if (state_nxt == state && timer != '1) timer_nxt = timer + 1'b1;
    else if (state_nxt == state)           timer_nxt = timer;
  end

  always_comb begin
    filt_nxt = '0;
    if (state == ST_PLL_LOCK && lock_qual)
      filt_nxt = (filt == '1) ? filt : filt + 1'b1;
  end

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      timer <= '0;
      filt  <= '0;
      ctl   <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      filt  <= filt_nxt;
      ctl   <= ctl_for(state_nxt);
    end
  end

  assign analog_iso_n         = ctl.analog_iso_n;
  assign analog_reset_n       = ctl.analog_reset_n;
  assign pll_iso_n            = ctl.pll_iso_n;
  assign pll_enable           = ctl.pll_enable;
  assign pll_reset_n          = ctl.pll_reset_n;
  assign serializer_enable    = ctl.serializer_enable;
  assign serializer_reset_n   = ctl.serializer_reset_n;
  assign deserializer_enable  = ctl.deserializer_enable;
  assign deserializer_reset_n = ctl.deserializer_reset_n;
  assign pll_lock             = ctl.pll_lock;
  assign phy_ready            = ctl.phy_ready;
  assign seq_fault            = ctl.seq_fault;
  assign seq_state            = state;

endmodule

// File: tb/tb_serdesphy_pma_seq.sv
// Directed bench for serdesphy_pma_seq: a vector table for the nominal
// bring-up and lock loss, plus hand sequences for timeouts and aborts.
module tb_serdesphy_pma_seq;

  logic clk_ref_24m = 1'b0;
  always #20 clk_ref_24m = ~clk_ref_24m;

  logic rst_n, phy_en, pll_lock_raw, pll_vco_ok, pll_cp_ok;
  logic serializer_ready, deserializer_ready;
  logic analog_iso_n, analog_reset_n, pll_iso_n, pll_enable, pll_reset_n;
  logic serializer_enable, serializer_reset_n, deserializer_enable, deserializer_reset_n;
  logic pll_lock, phy_ready, seq_fault;
  logic [2:0] seq_state;

  serdesphy_pma_seq dut (
    .clk_ref_24m(clk_ref_24m), .rst_n(rst_n), .phy_en(phy_en),
    .pll_lock_raw(pll_lock_raw), .pll_vco_ok(pll_vco_ok), .pll_cp_ok(pll_cp_ok),
    .serializer_ready(serializer_ready), .deserializer_ready(deserializer_ready),
    .analog_iso_n(analog_iso_n), .analog_reset_n(analog_reset_n),
    .pll_iso_n(pll_iso_n), .pll_enable(pll_enable), .pll_reset_n(pll_reset_n),
    .serializer_enable(serializer_enable), .serializer_reset_n(serializer_reset_n),
    .deserializer_enable(deserializer_enable), .deserializer_reset_n(deserializer_reset_n),
    .pll_lock(pll_lock), .phy_ready(phy_ready), .seq_fault(seq_fault),
    .seq_state(seq_state)
  );

  // {iso_a, rst_a, iso_p, pll_en, pll_rst_n, ser_en, ser_rst_n, des_en, des_rst_n, lock, ready, fault}
  wire [11:0] outs = {analog_iso_n, analog_reset_n, pll_iso_n, pll_enable, pll_reset_n,
                      serializer_enable, serializer_reset_n, deserializer_enable,
                      deserializer_reset_n, pll_lock, phy_ready, seq_fault};

  localparam logic [11:0] O_OFF   = 12'b0000_0000_0000;
  localparam logic [11:0] O_ISO   = 12'b1010_0000_0000;
  localparam logic [11:0] O_ANA   = 12'b1110_0000_0000;
  localparam logic [11:0] O_START = 12'b1111_0000_0000;
  localparam logic [11:0] O_LOCK  = 12'b1111_1000_0000;
  localparam logic [11:0] O_LANE  = 12'b1111_1111_1100;
  localparam logic [11:0] O_ACT   = 12'b1111_1111_1110;
  localparam logic [11:0] O_FAULT = 12'b0000_0000_0001;

  typedef struct {
    logic       en;
    logic       lock;
    logic       rdy;
    int         n;
    logic [2:0] st;
    logic [11:0] o;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nmis = 0;

  function automatic vec_t mk(logic en, logic lock, logic rdy, int n, logic [2:0] st, logic [11:0] o);
    vec_t v;
    v.en = en; v.lock = lock; v.rdy = rdy; v.n = n; v.st = st; v.o = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] exp_st, input logic [11:0] exp_o);
    nvec++;
    if (seq_state !== exp_st || outs !== exp_o) begin
      nmis++;
      $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
               name, seq_state, outs, exp_st, exp_o);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk_ref_24m);
    @(negedge clk_ref_24m);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget && seq_state !== s; i++) run(1);
    if (seq_state !== s) begin
      nvec++;
      nmis++;
      $display("FAIL %s: timed out, state=%0d required=%0d", name, seq_state, s);
    end
  endtask

  // Counts edges from the current (just-entered) state until it changes.
  task automatic count_residency(input logic [2:0] s, input bit glitch, output int cnt);
    cnt = 0;
    while (seq_state === s && cnt < 24100) begin
      if (glitch) pll_lock_raw = (cnt % 50 != 49);
      run(1);
      cnt++;
    end
    pll_lock_raw = 1'b1;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; phy_en = 1'b0; pll_lock_raw = 1'b1; pll_vco_ok = 1'b1; pll_cp_ok = 1'b1;
    serializer_ready = 1'b1; deserializer_ready = 1'b1;

    // Nominal bring-up: phy_en set before edge 1; ISO 24, ANA 48, START 48, LOCK 64, LANE 1.
    tbl.push_back(mk(0, 1, 1,  3, 3'd0, O_OFF));
    tbl.push_back(mk(1, 1, 1,  1, 3'd1, O_ISO));
    tbl.push_back(mk(1, 1, 1, 23, 3'd1, O_ISO));
    tbl.push_back(mk(1, 1, 1,  1, 3'd2, O_ANA));
    tbl.push_back(mk(1, 1, 1, 47, 3'd2, O_ANA));
    tbl.push_back(mk(1, 1, 1,  1, 3'd3, O_START));
    tbl.push_back(mk(1, 1, 1, 47, 3'd3, O_START));
    tbl.push_back(mk(1, 1, 1,  1, 3'd4, O_LOCK));
    tbl.push_back(mk(1, 1, 1, 63, 3'd4, O_LOCK));
    tbl.push_back(mk(1, 1, 1,  1, 3'd5, O_LANE));
    tbl.push_back(mk(1, 1, 1,  1, 3'd6, O_ACT));
    tbl.push_back(mk(1, 1, 1, 10, 3'd6, O_ACT));
    // Lock loss: two synchronizer edges, then FAULT on the third.
    tbl.push_back(mk(1, 0, 1,  2, 3'd6, O_ACT));
    tbl.push_back(mk(1, 0, 1,  1, 3'd7, O_FAULT));
    tbl.push_back(mk(1, 0, 1,  5, 3'd7, O_FAULT));
    tbl.push_back(mk(0, 0, 1,  1, 3'd0, O_OFF));

    #1 check("reset", 3'd0, O_OFF);
    run(2);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      phy_en = tbl[i].en;
      pll_lock_raw = tbl[i].lock;
      serializer_ready = tbl[i].rdy;
      deserializer_ready = tbl[i].rdy;
      run(tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].o);
    end

    // Lock timeout: never locks, FAULT exactly 24000 edges after PLL_LOCK entry.
    pll_lock_raw = 1'b0;
    phy_en = 1'b1;
    wait_state(3'd4, 200, "reach_lock_to");
    count_residency(3'd4, 1'b0, cnt);
    pll_lock_raw = 1'b0;
    check_int("lock_timeout_cycles", cnt, 24000);
    check("lock_timeout_state", 3'd7, O_FAULT);
    phy_en = 1'b0;
    run(1);
    check("lock_timeout_off", 3'd0, O_OFF);

    // Glitchy lock: one low cycle every 50 keeps the filter short of 64.
    pll_lock_raw = 1'b1;
    phy_en = 1'b1;
    wait_state(3'd4, 200, "reach_lock_glitch");
    count_residency(3'd4, 1'b1, cnt);
    check_int("glitch_timeout_cycles", cnt, 24000);
    check("glitch_timeout_state", 3'd7, O_FAULT);
    phy_en = 1'b0;
    run(1);
    check("glitch_off", 3'd0, O_OFF);

    // Abort mid-PLL_START.
    phy_en = 1'b1;
    wait_state(3'd3, 200, "reach_start");
    run(10);
    check("abort_pre", 3'd3, O_START);
    phy_en = 1'b0;
    run(1);
    check("abort_off", 3'd0, O_OFF);

    // Lane wait: deserializer not ready holds LANE_UP until it is.
    serializer_ready = 1'b1;
    deserializer_ready = 1'b0;
    phy_en = 1'b1;
    wait_state(3'd5, 400, "reach_lane");
    run(5);
    check("lane_wait", 3'd5, O_LANE);
    deserializer_ready = 1'b1;
    run(2);
    check("lane_sync", 3'd5, O_LANE);
    run(1);
    check("lane_active", 3'd6, O_ACT);

    // Asynchronous reset mid-ACTIVE.
    rst_n = 1'b0;
    #1 check("async_reset", 3'd0, O_OFF);
    run(2);
    check("reset_held", 3'd0, O_OFF);
    rst_n = 1'b1;
    run(1);
    check("after_reset", 3'd1, O_ISO);
    phy_en = 1'b0;
    run(1);
    check("final_off", 3'd0, O_OFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
